counter_updn: RTL and testbench

COUNTER_UPDN -- requirements
Module: counter_updn

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_next.sv | 43 ++++
 rtl/counter_updn.sv | 58 +++++
 tb/tb_counter_updn.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter slice.
// Direction encoding plus the default terminal count for a given width.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // All-ones value of the given width (2..32); the shift avoids a 33-bit 2**w-1.
  function automatic logic [31:0] default_max(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and terminal-detect logic for counter_updn.
// term is purely out/cin/up so load never sits on the cascade carry path.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = WIDTH'(default_max(WIDTH)),
  parameter int unsigned      SATURATE = 0
) (
  input  logic [WIDTH-1:0] out_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             up_i,
  input  logic             cin_i,
  input  logic             load_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] next_o,
  output logic             term_o
);

  logic at_max, at_zero;

  assign at_max  = (out_i == MAX);
  assign at_zero = (out_i == '0);
  assign term_o  = cin_i & ((up_i == DIR_UP) ? at_max : at_zero);

  always_comb begin
    next_o = out_i;
    if (clr_i) begin
      next_o = '0;
    end else if (load_i) begin
      next_o = (data_i > MAX) ? MAX : data_i;
    end else if (cin_i) begin
      if (up_i == DIR_UP) begin
        if (at_max) next_o = (SATURATE != 0) ? MAX : '0;
        else        next_o = out_i + WIDTH'(1);
      end else begin
        if (at_zero) next_o = (SATURATE != 0) ? '0 : MAX;
        else         next_o = out_i - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/counter_updn.sv
// Cascadable up/down modulo counter with load, clear and sticky overflow.
// cout is combinational so N stages chain into an N*WIDTH-bit counter.
module counter_updn
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = WIDTH'(default_max(WIDTH)),
  parameter int unsigned      SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             clr,
  input  logic             cin,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             term;

  counter_next #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .SATURATE (SATURATE)
  ) u_next (
    .out_i  (out_q),
    .data_i (data),
    .up_i   (up),
    .cin_i  (cin),
    .load_i (load),
    .clr_i  (clr),
    .next_o (out_d),
    .term_o (term)
  );

  // Terminal events only latch ovf when the edge actually counts.
  assign ovf_d = (clr | load) ? 1'b0 : (ovf_q | term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out  = out_q;
  assign cout = term;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_counter_updn.sv
// Directed bench for counter_updn: decade wrap, saturate, clamp/priority,
// two-stage cascade, full-range wrap and asynchronous reset.
module tb_counter_updn;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // decade counter, wrapping
  logic [7:0] d_data, d_out;
  logic       d_load, d_clr, d_cin, d_up, d_cout, d_ovf;
  // decade counter, saturating
  logic [7:0] s_data, s_out;
  logic       s_load, s_clr, s_cin, s_up, s_cout, s_ovf;
  // two-stage full-range cascade
  logic [7:0] c_data, lo_out, hi_out;
  logic       c_load, c_clr, c_cin, c_up, lo_cout, lo_ovf, hi_cout, hi_ovf;

  counter_updn #(.WIDTH(8), .MAX(8'd9), .SATURATE(0)) u_dec (
    .clk(clk), .rst_n(rst_n), .data(d_data), .load(d_load), .clr(d_clr),
    .cin(d_cin), .up(d_up), .out(d_out), .cout(d_cout), .ovf(d_ovf));

  counter_updn #(.WIDTH(8), .MAX(8'd9), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .data(s_data), .load(s_load), .clr(s_clr),
    .cin(s_cin), .up(s_up), .out(s_out), .cout(s_cout), .ovf(s_ovf));

  counter_updn #(.WIDTH(8)) u_lo (
    .clk(clk), .rst_n(rst_n), .data(c_data), .load(c_load), .clr(c_clr),
    .cin(c_cin), .up(c_up), .out(lo_out), .cout(lo_cout), .ovf(lo_ovf));

  counter_updn #(.WIDTH(8)) u_hi (
    .clk(clk), .rst_n(rst_n), .data(8'd0), .load(1'b0), .clr(c_clr),
    .cin(lo_cout), .up(c_up), .out(hi_out), .cout(hi_cout), .ovf(hi_ovf));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int dec_out [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dec_ovf [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int dec_cout[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int sat_out [4]  = '{1, 0, 0, 0};
  int sat_ovf [4]  = '{0, 0, 1, 1};
  int sat_cout[4]  = '{0, 0, 1, 1};
  int pulses;

  initial begin
    rst_n = 1'b0;
    {d_load, d_clr, d_cin, d_up} = '0; d_data = '0;
    {s_load, s_clr, s_cin, s_up} = '0; s_data = '0;
    {c_load, c_clr, c_cin, c_up} = '0; c_data = '0;
    #12;
    chk("rst_d_out", d_out, 0);
    chk("rst_d_ovf", d_ovf, 0);
    chk("rst_d_cout", d_cout, 0);
    chk("rst_lo_out", lo_out, 0);
    chk("rst_hi_out", hi_out, 0);
    rst_n = 1'b1;

    // decade wrap
    d_cin = 1'b1; d_up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("dec_cout%0d", k), d_cout, dec_cout[k]);
      tick();
      chk($sformatf("dec_out%0d", k), d_out, dec_out[k]);
      chk($sformatf("dec_ovf%0d", k), d_ovf, dec_ovf[k]);
    end
    d_cin = 1'b0; tick();
    chk("dec_hold", d_out, 2);
    chk("dec_hold_ovf", d_ovf, 1);
    d_cin = 1'b1; d_up = 1'b0; tick();
    chk("dec_dirchg", d_out, 1);

    // load clamp, then clr beats load
    d_cin = 1'b0; d_load = 1'b1; d_data = 8'd200; tick();
    chk("clamp_out", d_out, 9);
    chk("clamp_ovf", d_ovf, 0);
    d_clr = 1'b1; tick();
    chk("clr_prio", d_out, 0);
    d_clr = 1'b0; d_load = 1'b0;
    d_cin = 1'b1; d_up = 1'b0; #1;
    chk("dec_borrow", d_cout, 1);
    tick();
    chk("dec_wrapdn", d_out, 9);
    chk("dec_wrapdn_ovf", d_ovf, 1);
    d_cin = 1'b0;

    // saturate down
    s_load = 1'b1; s_data = 8'd2; tick();
    chk("sat_load", s_out, 2);
    s_load = 1'b0; s_cin = 1'b1; s_up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sat_cout%0d", k), s_cout, sat_cout[k]);
      tick();
      chk($sformatf("sat_out%0d", k), s_out, sat_out[k]);
      chk($sformatf("sat_ovf%0d", k), s_ovf, sat_ovf[k]);
    end
    // saturate up
    s_cin = 1'b0; s_load = 1'b1; s_data = 8'd8; tick();
    s_load = 1'b0; s_cin = 1'b1; s_up = 1'b1; tick();
    chk("satup_9", s_out, 9);
    chk("satup_ovf0", s_ovf, 0);
    chk("satup_cout", s_cout, 1);
    tick();
    chk("satup_hold", s_out, 9);
    chk("satup_ovf1", s_ovf, 1);
    s_cin = 1'b0;

    // cascade 256 enabled clocks
    c_cin = 1'b1; c_up = 1'b1; pulses = 0;
    for (int i = 0; i < 256; i++) begin
      if (lo_cout) pulses++;
      tick();
    end
    chk("casc_pulses", pulses, 1);
    chk("casc_value", {16'd0, hi_out, lo_out}, 32'h0100);
    chk("casc_lo_ovf", lo_ovf, 1);
    c_cin = 1'b0;
    c_load = 1'b1; c_data = 8'd255; tick();
    chk("casc_ld255", lo_out, 255);
    c_cin = 1'b1; c_data = 8'd5; #1;
    chk("casc_load_cout", lo_cout, 1);
    tick();
    chk("casc_lo_after", lo_out, 5);
    chk("casc_hi_after", hi_out, 2);
    c_cin = 1'b0;

    // full-range wrap
    c_data = 8'd255; tick();
    c_load = 1'b0; c_cin = 1'b1; #1;
    chk("full_cout", lo_cout, 1);
    chk("full_ovf_pre", lo_ovf, 0);
    tick();
    chk("full_out", lo_out, 0);
    chk("full_ovf", lo_ovf, 1);
    chk("full_hi", hi_out, 3);
    c_cin = 1'b0;

    // async reset between edges
    c_load = 1'b1; c_data = 8'h37; tick();
    c_load = 1'b0;
    chk("pre_rst", lo_out, 32'h37);
    c_cin = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lo", lo_out, 0);
    chk("arst_lo_ovf", lo_ovf, 0);
    chk("arst_hi", hi_out, 0);
    chk("arst_cout", lo_cout, 0);
    chk("arst_d_ovf", d_ovf, 0);
    chk("arst_d_out", d_out, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_resume", lo_out, 1);
    c_cin = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
